// File: rtl/fb_reader.sv
// fb_reader: PLB IPIF read master streaming a framebuffer into a 64-bit FIFO
//   PLB_clk/Bus2IP_Reset : clock, async active-high reset
//   enable               : keep streaming frames while high
//   fifo_*               : packed entry ([0:31] even word, [32:63] odd word), write strobe, full
//   IP2Bus_*/Bus2IP_*    : single-beat 32-bit master read interface (writes never issued)
//   frame_done           : pulses with the FIFO write of a frame's last entry
//   rd_error             : sticky bus error/timeout flag
module fb_reader #(
   parameter logic [31:0] C_FB_BASE  = 32'h4800_0000,
   parameter int          C_FB_WORDS = 307200,
   parameter int          C_IDX_W    = 19
) (
   input  logic        PLB_clk,
   input  logic        Bus2IP_Reset,
   input  logic        enable,
   output logic [0:63] fifo_data,
   output logic        fifo_wr_en,
   input  logic        fifo_full,
   output logic        IP2Bus_MstRd_Req,
   output logic        IP2Bus_MstWr_Req,
   output logic [0:31] IP2Bus_Mst_Addr,
   output logic [0:3]  IP2Bus_Mst_BE,
   output logic        IP2Bus_Mst_Lock,
   output logic        IP2Bus_Mst_Reset,
   input  logic        Bus2IP_Mst_CmdAck,
   input  logic        Bus2IP_Mst_Cmplt,
   input  logic        Bus2IP_Mst_Error,
   input  logic        Bus2IP_Mst_Rearbitrate,
   input  logic        Bus2IP_Mst_Cmd_Timeout,
   input  logic [0:31] Bus2IP_MstRd_d,
   input  logic        Bus2IP_MstRd_src_rdy_n,
   output logic        IP2Bus_MstRd_dst_rdy_n,
   output logic        frame_done,
   output logic        rd_error
);
   typedef enum logic [2:0] {IDLE, REQ, REQ_GAP, WAIT, PUSH} state_t;
   localparam logic [C_IDX_W-1:0] LAST = C_IDX_W'(C_FB_WORDS - 1);
   state_t state;
   logic [C_IDX_W-1:0] idx, idx_inc, idx_wrap;
   logic half, got, in_cmd, got_now, bad;
   function automatic logic [31:0] addr_of(input logic [C_IDX_W-1:0] i);
      return C_FB_BASE + 32'({i, 2'b00});
   endfunction
   // A command is live in WAIT, or in REQ on the cycle it is acknowledged
   // (ack and completion may land together with the request).
   always_comb begin
      in_cmd   = state == WAIT || (state == REQ && Bus2IP_Mst_CmdAck);
      got_now  = got || !Bus2IP_MstRd_src_rdy_n;
      bad      = Bus2IP_Mst_Error || Bus2IP_Mst_Cmd_Timeout;
      idx_inc  = idx + 1'b1;
      idx_wrap = idx == LAST ? '0 : idx_inc;
   end
   assign fifo_wr_en       = state == PUSH && !fifo_full;
   assign frame_done       = fifo_wr_en && idx == LAST;
   assign IP2Bus_MstWr_Req = 1'b0;
   assign IP2Bus_Mst_BE    = 4'b1111;
   assign IP2Bus_Mst_Lock  = 1'b0;
   assign IP2Bus_Mst_Reset = 1'b0;
   always_ff @(posedge PLB_clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) begin
         state                  <= IDLE;
         idx                    <= '0;
         half                   <= 1'b0;
         got                    <= 1'b0;
         fifo_data              <= '0;
         IP2Bus_Mst_Addr        <= '0;
         IP2Bus_MstRd_Req       <= 1'b0;
         IP2Bus_MstRd_dst_rdy_n <= 1'b1;
         rd_error               <= 1'b0;
      end else begin
         case (state)
            IDLE: if (enable) begin
               state                  <= REQ;
               IP2Bus_Mst_Addr        <= addr_of(idx);
               IP2Bus_MstRd_Req       <= 1'b1;
               IP2Bus_MstRd_dst_rdy_n <= 1'b0;
            end
            REQ: if (!Bus2IP_Mst_CmdAck && Bus2IP_Mst_Rearbitrate) begin
               state                  <= REQ_GAP;
               IP2Bus_MstRd_Req       <= 1'b0;
               IP2Bus_MstRd_dst_rdy_n <= 1'b1;
            end
            REQ_GAP: begin
               state                  <= REQ;
               IP2Bus_MstRd_Req       <= 1'b1;
               IP2Bus_MstRd_dst_rdy_n <= 1'b0;
            end
            PUSH: if (!fifo_full) begin
               half                   <= 1'b0;
               idx                    <= idx_wrap;
               IP2Bus_Mst_Addr        <= addr_of(idx_wrap);
               state                  <= enable ? REQ : IDLE;
               IP2Bus_MstRd_Req       <= enable;
               IP2Bus_MstRd_dst_rdy_n <= !enable;
            end
            default: ;
         endcase
         if (in_cmd) begin
            if (!Bus2IP_MstRd_src_rdy_n) begin
               if (half) fifo_data[32:63] <= Bus2IP_MstRd_d;
               else fifo_data[0:31] <= Bus2IP_MstRd_d;
            end
            if (!Bus2IP_Mst_Cmplt) begin
               state                  <= WAIT;
               got                    <= got_now;
               IP2Bus_MstRd_Req       <= 1'b0;
               IP2Bus_MstRd_dst_rdy_n <= 1'b0;
            end else if (bad || !got_now) begin
               // Failed or data-less completion: reissue the same word; any
               // captured half is overwritten by the retry.
               rd_error               <= rd_error || bad;
               got                    <= 1'b0;
               state                  <= REQ;
               IP2Bus_MstRd_Req       <= 1'b1;
               IP2Bus_MstRd_dst_rdy_n <= 1'b0;
            end else if (!half) begin
               got                    <= 1'b0;
               half                   <= 1'b1;
               idx                    <= idx_inc;
               IP2Bus_Mst_Addr        <= addr_of(idx_inc);
               state                  <= enable ? REQ : IDLE;
               IP2Bus_MstRd_Req       <= enable;
               IP2Bus_MstRd_dst_rdy_n <= !enable;
            end else begin
               got                    <= 1'b0;
               state                  <= PUSH;
               IP2Bus_MstRd_Req       <= 1'b0;
               IP2Bus_MstRd_dst_rdy_n <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fb_reader.sv
// tb_fb_reader: table-driven cycle vectors plus reset/restart sequence for fb_reader
module tb_fb_reader;
   logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, fifo_full = 1'b0;
   logic        ack = 1'b0, cmplt = 1'b0, err = 1'b0, rearb = 1'b0, tmo = 1'b0, src_rdy_n = 1'b1;
   logic [0:31] rd_d = '0;
   logic [0:63] fifo_data;
   logic        fifo_wr_en, rd_req, wr_req, lock, mst_rst, dst_rdy_n, frame_done, rd_error;
   logic [0:31] addr;
   logic [0:3]  be;
   int checks = 0, errors = 0;

   fb_reader #(.C_FB_BASE(32'h4800_0000), .C_FB_WORDS(4), .C_IDX_W(3)) dut (
      .PLB_clk(clk), .Bus2IP_Reset(rst), .enable(enable),
      .fifo_data(fifo_data), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
      .IP2Bus_MstRd_Req(rd_req), .IP2Bus_MstWr_Req(wr_req), .IP2Bus_Mst_Addr(addr),
      .IP2Bus_Mst_BE(be), .IP2Bus_Mst_Lock(lock), .IP2Bus_Mst_Reset(mst_rst),
      .Bus2IP_Mst_CmdAck(ack), .Bus2IP_Mst_Cmplt(cmplt), .Bus2IP_Mst_Error(err),
      .Bus2IP_Mst_Rearbitrate(rearb), .Bus2IP_Mst_Cmd_Timeout(tmo),
      .Bus2IP_MstRd_d(rd_d), .Bus2IP_MstRd_src_rdy_n(src_rdy_n),
      .IP2Bus_MstRd_dst_rdy_n(dst_rdy_n), .frame_done(frame_done), .rd_error(rd_error)
   );

   always #5 clk = ~clk;

   // in  = {enable, CmdAck, Cmplt, Error, Rearbitrate, src_rdy_n, fifo_full}
   // ex  = {MstRd_Req, dst_rdy_n, fifo_wr_en, frame_done, rd_error}
   typedef struct {
      logic [6:0]  in;
      logic [31:0] d;
      logic [4:0]  ex;
      logic [31:0] a;
      logic        cd;
      logic [63:0] fd;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic [6:0] in, input logic [31:0] d, input logic [4:0] ex,
                      input logic [31:0] a, input logic cd, input logic [63:0] fd);
      tbl.push_back('{in, d, ex, a, cd, fd});
   endtask

   task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   initial begin
      add(7'b1000010, 32'h0,         5'b01000, 32'h0,         1'b0, 64'h0);
      add(7'b1110000, 32'h11223344,  5'b10000, 32'h4800_0000, 1'b0, 64'h0);
      add(7'b1100010, 32'h0,         5'b10000, 32'h4800_0004, 1'b0, 64'h0);
      add(7'b1000000, 32'h55667788,  5'b00000, 32'h4800_0004, 1'b0, 64'h0);
      add(7'b1010010, 32'h0,         5'b00000, 32'h4800_0004, 1'b0, 64'h0);
      add(7'b1000010, 32'h0,         5'b01100, 32'h4800_0004, 1'b1, 64'h1122334455667788);
      add(7'b1000010, 32'h0,         5'b10000, 32'h4800_0008, 1'b0, 64'h0);
      add(7'b1000110, 32'h0,         5'b10000, 32'h4800_0008, 1'b0, 64'h0);
      add(7'b1000010, 32'h0,         5'b01000, 32'h4800_0008, 1'b0, 64'h0);
      add(7'b1000010, 32'h0,         5'b10000, 32'h4800_0008, 1'b0, 64'h0);
      add(7'b1111000, 32'hDEADBEEF,  5'b10000, 32'h4800_0008, 1'b0, 64'h0);
      add(7'b1110000, 32'hAAAA0001,  5'b10001, 32'h4800_0008, 1'b0, 64'h0);
      add(7'b1110001, 32'hBBBB0002,  5'b10001, 32'h4800_000C, 1'b0, 64'h0);
      for (int i = 0; i < 5; i++)
         add(7'b1000011, 32'h0,      5'b01001, 32'h4800_000C, 1'b1, 64'hAAAA0001BBBB0002);
      add(7'b1000010, 32'h0,         5'b01111, 32'h4800_000C, 1'b1, 64'hAAAA0001BBBB0002);
      add(7'b0110000, 32'h01010101,  5'b10001, 32'h4800_0000, 1'b0, 64'h0);
      add(7'b0000010, 32'h0,         5'b01001, 32'h4800_0004, 1'b0, 64'h0);
      add(7'b1000010, 32'h0,         5'b01001, 32'h4800_0004, 1'b0, 64'h0);
      add(7'b1110000, 32'h02020202,  5'b10001, 32'h4800_0004, 1'b0, 64'h0);
      add(7'b1000010, 32'h0,         5'b01101, 32'h4800_0004, 1'b1, 64'h0101010102020202);
      add(7'b1000010, 32'h0,         5'b10001, 32'h4800_0008, 1'b0, 64'h0);

      #12;
      chk("reset_req", -1, 64'(rd_req), 64'd0);
      chk("reset_dst_rdy_n", -1, 64'(dst_rdy_n), 64'd1);
      chk("reset_addr", -1, 64'(addr), 64'd0);
      chk("reset_fifo_data", -1, fifo_data, 64'd0);
      chk("reset_wr_en", -1, 64'(fifo_wr_en), 64'd0);
      chk("reset_rd_error", -1, 64'(rd_error), 64'd0);
      chk("const_outputs", -1, 64'({wr_req, be, lock, mst_rst}), 64'b0_1111_0_0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[r]) begin
         @(negedge clk);
         {enable, ack, cmplt, err, rearb, src_rdy_n, fifo_full} = tbl[r].in;
         rd_d = tbl[r].d;
         #1;
         chk("req", r, 64'(rd_req), 64'(tbl[r].ex[4]));
         chk("dst_rdy_n", r, 64'(dst_rdy_n), 64'(tbl[r].ex[3]));
         chk("fifo_wr_en", r, 64'(fifo_wr_en), 64'(tbl[r].ex[2]));
         chk("frame_done", r, 64'(frame_done), 64'(tbl[r].ex[1]));
         chk("rd_error", r, 64'(rd_error), 64'(tbl[r].ex[0]));
         chk("addr", r, 64'(addr), 64'(tbl[r].a));
         if (tbl[r].cd) chk("fifo_data", r, fifo_data, tbl[r].fd);
      end

      // Reset asserted while a command is outstanding in WAIT.
      @(negedge clk);
      {enable, ack, cmplt, err, rearb, src_rdy_n, fifo_full} = 7'b1100010;
      @(negedge clk);
      {ack, cmplt, src_rdy_n} = 3'b010;
      rd_d = 32'hCAFEF00D;
      #1;
      chk("wait_req", 100, 64'(rd_req), 64'd0);
      chk("wait_dst_rdy_n", 100, 64'(dst_rdy_n), 64'd0);
      rst = 1'b1;
      #1;
      chk("async_rst_dst_rdy_n", 101, 64'(dst_rdy_n), 64'd1);
      chk("async_rst_addr", 101, 64'(addr), 64'd0);
      chk("async_rst_rd_error", 101, 64'(rd_error), 64'd0);
      @(negedge clk);
      chk("rst_no_write", 102, 64'(fifo_wr_en), 64'd0);
      chk("rst_fifo_data", 102, fifo_data, 64'd0);
      {ack, cmplt, src_rdy_n} = 3'b001;
      rst = 1'b0;
      begin
         int n = 0;
         while (!rd_req && n < 5) begin
            @(negedge clk);
            n++;
         end
         chk("restart_req_seen", 103, 64'(rd_req), 64'd1);
         chk("restart_addr", 103, 64'(addr), 64'h4800_0000);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
